// File: rtl/systolic_feeder_pkg.sv
// Shared types and defaults for the MAC-array operand feeder.
package systolic_feeder_pkg;

    localparam int systolic_size_c  = 4;
    localparam int mac_data_width_c = 8;
    localparam int feeder_depth_c   = 16;

    typedef logic [mac_data_width_c-1:0]   t_mac_data;
    typedef logic [2*mac_data_width_c-1:0] t_mac_mul_data;

    typedef enum logic [1:0] {
        IDLE,
        FEED,
        DONE
    } feed_state_e;

endpackage

// File: rtl/systolic_feeder_if.sv
// Load handshake and skewed feed bundle between controller and feeder.
interface systolic_feeder_if
    import systolic_feeder_pkg::*;
#(
    parameter int SIZE = systolic_size_c
) ();

    logic                  load_valid_i;
    logic                  load_ready_o;
    t_mac_data [SIZE-1:0]  load_a_i;
    t_mac_data [SIZE-1:0]  load_b_i;
    logic                  load_last_i;
    t_mac_data [SIZE-1:0]  a_rows_o;
    t_mac_data [SIZE-1:0]  b_columns_o;
    logic                  feed_valid_o;
    logic                  busy_o;
    logic                  done_o;

    modport master (
        output load_valid_i, load_a_i, load_b_i, load_last_i,
        input  load_ready_o, a_rows_o, b_columns_o,
        input  feed_valid_o, busy_o, done_o
    );

    modport slave (
        input  load_valid_i, load_a_i, load_b_i, load_last_i,
        output load_ready_o, a_rows_o, b_columns_o,
        output feed_valid_o, busy_o, done_o
    );

endinterface

// File: rtl/systolic_operand_buffer.sv
// DEPTH x SIZE operand store; lane i reads entry t-i, masked to zero
// outside the window [0, k_len).
module systolic_operand_buffer
    import systolic_feeder_pkg::*;
#(
    parameter int SIZE  = systolic_size_c,
    parameter int DEPTH = feeder_depth_c,
    parameter int PW    = $clog2(DEPTH),
    parameter int TW    = $clog2(DEPTH + SIZE),
    parameter int KW    = PW + 1
) (
    input  logic                 clock_i,
    input  logic                 wr_en,
    input  logic [PW-1:0]        wr_idx,
    input  t_mac_data [SIZE-1:0] wr_data,
    input  logic [TW-1:0]        t,
    input  logic [KW-1:0]        k_len,
    output t_mac_data [SIZE-1:0] rd_data
);

    t_mac_data [SIZE-1:0] mem [DEPTH];
    logic [SIZE-1:0]      lane_vld;

    always_ff @(posedge clock_i) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    for (genvar i = 0; i < SIZE; i++) begin : g_lane
        logic [TW:0] d;
        assign d = {1'b0, t} - (TW+1)'(i);
        // Borrow bit flags t < i; upper bound keeps d inside the tile.
        assign lane_vld[i] = !d[TW] && (d < (TW+1)'(k_len));
        assign rd_data[i]  = lane_vld[i] ? mem[d[PW-1:0]][i] : '0;
    end

endmodule

// File: rtl/systolic_feeder.sv
// Buffers one tile of A/B operand vectors and replays them diagonally
// skewed into the systolic array.
module systolic_feeder
    import systolic_feeder_pkg::*;
#(
    parameter int SIZE  = systolic_size_c,
    parameter int DEPTH = feeder_depth_c
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    systolic_feeder_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = $clog2(DEPTH + SIZE);
    localparam int KW = PW + 1;

    feed_state_e          state, state_n;
    logic [PW-1:0]        wr_ptr;
    logic [TW-1:0]        t;
    logic [KW-1:0]        k_len;
    t_mac_data [SIZE-1:0] a_rd, b_rd;
    t_mac_data [SIZE-1:0] a_q, b_q;
    logic                 fv_q;
    logic                 load_fire;
    logic                 last_vec;
    logic                 t_end;
    logic                 feeding;

    assign load_fire = bus.load_valid_i && bus.load_ready_o;
    assign last_vec  = bus.load_last_i || (wr_ptr == PW'(DEPTH - 1));
    // One drain step past the last skewed column clears the outputs.
    assign t_end     = (t == TW'(k_len) + TW'(SIZE - 1));
    assign feeding   = (state == FEED) && !t_end;

    systolic_operand_buffer #(
        .SIZE (SIZE),
        .DEPTH(DEPTH)
    ) u_buf_a (
        .clock_i(clock_i),
        .wr_en  (load_fire),
        .wr_idx (wr_ptr),
        .wr_data(bus.load_a_i),
        .t      (t),
        .k_len  (k_len),
        .rd_data(a_rd)
    );

    systolic_operand_buffer #(
        .SIZE (SIZE),
        .DEPTH(DEPTH)
    ) u_buf_b (
        .clock_i(clock_i),
        .wr_en  (load_fire),
        .wr_idx (wr_ptr),
        .wr_data(bus.load_b_i),
        .t      (t),
        .k_len  (k_len),
        .rd_data(b_rd)
    );

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (load_fire && last_vec) state_n = FEED;
            FEED:    if (t_end) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state  <= IDLE;
            wr_ptr <= '0;
            t      <= '0;
            k_len  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            fv_q   <= 1'b0;
        end else begin
            state <= state_n;
            fv_q  <= feeding;
            a_q   <= feeding ? a_rd : '0;
            b_q   <= feeding ? b_rd : '0;
            t     <= (state == FEED) ? t + 1'b1 : '0;
            if (load_fire) begin
                wr_ptr <= last_vec ? '0 : wr_ptr + 1'b1;
                if (last_vec) k_len <= KW'(wr_ptr) + 1'b1;
            end
        end
    end

    assign bus.load_ready_o = (state == IDLE);
    assign bus.a_rows_o     = a_q;
    assign bus.b_columns_o  = b_q;
    assign bus.feed_valid_o = fv_q;
    assign bus.busy_o       = (state != IDLE);
    assign bus.done_o       = (state == DONE);

endmodule
